// File: rtl/spi_flash_dma_drain.sv
// rtl/spi_flash_dma_drain.sv - AHB-side DMA drain: pops flash read FIFO words and issues single-beat AHB writes
module spi_flash_dma_drain #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        ahbclk,
  input  logic        ahbrst,
  input  logic        i_start,
  input  logic [31:0] i_dma_addr,
  input  logic [23:0] i_byte_count,
  input  logic        i_abort,
  input  logic        i_fifo_empty,
  input  logic [31:0] i_fifo_rdata,
  output logic        o_fifo_rd_en,
  output logic [31:0] o_addr,
  output logic [31:0] o_wr_data,
  output logic        o_rd0_wr1,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  localparam int WW = $clog2(TIMEOUT_CYC);
  localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WRITE, DONE, ABORT} state_t;

  state_t        state;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic [22:0]   count_q;
  logic [WW-1:0] wait_q;
  logic [24:0]   byte_round;
  logic [22:0]   words;

  // Partial trailing word rounds up to a full word
  assign byte_round = {1'b0, i_byte_count} + 25'd3;
  assign words      = byte_round[24:2];

  assign o_fifo_rd_en = (state == FETCH) && !i_abort && !i_fifo_empty;
  assign o_addr       = addr_q;
  assign o_wr_data    = data_q;
  assign o_rd0_wr1    = o_valid;

  always_ff @(posedge ahbclk) begin
    if (ahbrst) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      wait_q  <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_error <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      o_error <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            addr_q  <= {i_dma_addr[31:2], 2'b00};
            count_q <= words;
            if (words != '0) begin
              state  <= FETCH;
              o_busy <= 1'b1;
            end else begin
              state  <= DONE;
              o_done <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (i_abort) begin
            state   <= ABORT;
            o_error <= 1'b1;
            o_busy  <= 1'b0;
          end else if (!i_fifo_empty) begin
            data_q  <= i_fifo_rdata;
            wait_q  <= '0;
            o_valid <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            wait_q  <= '0;
            addr_q  <= addr_q + 32'd4;
            count_q <= count_q - 23'd1;
            if (count_q == 23'd1) begin
              state  <= DONE;
              o_done <= 1'b1;
              o_busy <= 1'b0;
            end else if (i_abort) begin
              state   <= ABORT;
              o_error <= 1'b1;
              o_busy  <= 1'b0;
            end else begin
              state <= FETCH;
            end
          end else if (wait_q == WAIT_MAX) begin
            // Slave never accepted: withdraw the request and terminate
            o_valid <= 1'b0;
            wait_q  <= '0;
            state   <= ABORT;
            o_error <= 1'b1;
            o_busy  <= 1'b0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        ABORT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
